// File: rtl/ps2_packet_decoder.sv
// ps2_packet_decoder: assembles 3-byte PS/2 mouse movement packets into
// registered 9-bit two's-complement X/Y deltas, button states and overflow flags.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   byte_data       received byte, valid only with byte_valid
//   byte_valid      one byte per high cycle
//   byte_err        receiver parity/frame error, qualifies byte_valid
//   x_axis, y_axis  {sign, data} deltas, optionally saturated on overflow
//   btn_left/right/middle, x_ovf, y_ovf  fields of the last complete packet
//   pkt_valid       one-cycle pulse when outputs are updated
//   sync_err        one-cycle pulse on misaligned byte, byte error or timeout
module ps2_packet_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter bit          SAT_ON_OVF     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       byte_err,
    output logic [8:0] x_axis,
    output logic [8:0] y_axis,
    output logic       btn_left,
    output logic       btn_right,
    output logic       btn_middle,
    output logic       x_ovf,
    output logic       y_ovf,
    output logic       pkt_valid,
    output logic       sync_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       status_q, status_d;
    logic [7:0]       xdat_q, xdat_d;
    logic [8:0]       x_axis_q, x_axis_d;
    logic [8:0]       y_axis_q, y_axis_d;
    logic [2:0]       btn_q, btn_d;
    logic [1:0]       ovf_q, ovf_d;
    logic             pkt_valid_q, pkt_valid_d;
    logic             sync_err_q, sync_err_d;

    logic byte_ok_c;
    logic byte_bad_c;

    // Saturate to +/-255 (never -256) so the downstream magnitude cannot wrap.
    function automatic logic [8:0] form_axis(input logic sign, input logic ovf,
                                             input logic [7:0] data);
        if (SAT_ON_OVF && ovf) begin
            return sign ? 9'h101 : 9'h0FF;
        end
        return {sign, data};
    endfunction

    assign byte_ok_c  = byte_valid & ~byte_err;
    assign byte_bad_c = byte_valid & byte_err;

    // Packet FSM, inter-byte timeout and output formation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        status_d    = status_q;
        xdat_d      = xdat_q;
        x_axis_d    = x_axis_q;
        y_axis_d    = y_axis_q;
        btn_d       = btn_q;
        ovf_d       = ovf_q;
        pkt_valid_d = 1'b0;
        sync_err_d  = 1'b0;

        if (byte_bad_c) begin
            state_d    = WAIT_B0;
            cnt_d      = '0;
            sync_err_d = 1'b1;
        end else begin
            unique case (state_q)
                WAIT_B0: begin
                    cnt_d = '0;
                    if (byte_ok_c) begin
                        // Bit 3 is always set in a status byte; use it to find alignment.
                        if (byte_data[3]) begin
                            status_d = byte_data;
                            state_d  = WAIT_B1;
                        end else begin
                            sync_err_d = 1'b1;
                        end
                    end
                end
                WAIT_B1: begin
                    if (byte_ok_c) begin
                        xdat_d  = byte_data;
                        cnt_d   = '0;
                        state_d = WAIT_B2;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        sync_err_d = 1'b1;
                        state_d    = WAIT_B0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WAIT_B2: begin
                    if (byte_ok_c) begin
                        x_axis_d    = form_axis(status_q[4], status_q[6], xdat_q);
                        y_axis_d    = form_axis(status_q[5], status_q[7], byte_data);
                        btn_d       = status_q[2:0];
                        ovf_d       = status_q[7:6];
                        pkt_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = WAIT_B0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d      = '0;
                        sync_err_d = 1'b1;
                        state_d    = WAIT_B0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = WAIT_B0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_B0;
            cnt_q       <= '0;
            status_q    <= '0;
            xdat_q      <= '0;
            x_axis_q    <= '0;
            y_axis_q    <= '0;
            btn_q       <= '0;
            ovf_q       <= '0;
            pkt_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            status_q    <= status_d;
            xdat_q      <= xdat_d;
            x_axis_q    <= x_axis_d;
            y_axis_q    <= y_axis_d;
            btn_q       <= btn_d;
            ovf_q       <= ovf_d;
            pkt_valid_q <= pkt_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign x_axis     = x_axis_q;
    assign y_axis     = y_axis_q;
    assign btn_left   = btn_q[0];
    assign btn_right  = btn_q[1];
    assign btn_middle = btn_q[2];
    assign x_ovf      = ovf_q[0];
    assign y_ovf      = ovf_q[1];
    assign pkt_valid  = pkt_valid_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_ps2_packet_decoder.sv
// Bench for ps2_packet_decoder: a saturating and a raw instance share the
// byte stream; expected packets are queued when driven and popped on pkt_valid.
module tb_ps2_packet_decoder;

    localparam int unsigned T = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_err = 1'b0;

    logic [8:0] x_s, y_s, x_r, y_r;
    logic       bl_s, br_s, bm_s, xo_s, yo_s, pv_s, se_s;
    logic       bl_r, br_r, bm_r, xo_r, yo_r, pv_r, se_r;

    ps2_packet_decoder #(.TIMEOUT_CYCLES(T), .SAT_ON_OVF(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_err(byte_err), .x_axis(x_s), .y_axis(y_s), .btn_left(bl_s),
        .btn_right(br_s), .btn_middle(bm_s), .x_ovf(xo_s), .y_ovf(yo_s),
        .pkt_valid(pv_s), .sync_err(se_s)
    );

    ps2_packet_decoder #(.TIMEOUT_CYCLES(T), .SAT_ON_OVF(1'b0)) u_raw (
        .clk(clk), .rst_n(rst_n), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_err(byte_err), .x_axis(x_r), .y_axis(y_r), .btn_left(bl_r),
        .btn_right(br_r), .btn_middle(bm_r), .x_ovf(xo_r), .y_ovf(yo_r),
        .pkt_valid(pv_r), .sync_err(se_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] x;
        logic [8:0] y;
        logic [8:0] xr;
        logic [8:0] yr;
        logic [2:0] btn;
        logic [1:0] ovf;
        int         due;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   ncnt = 0;
    int   sync_seen = 0;
    int   sync_exp = 0;
    logic [8:0] last_x = 9'h000;
    logic [8:0] last_y = 9'h000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Reference packet: axis = {sign, data}; overflow forces +255 / -255.
    function automatic exp_t model(input logic [7:0] b0, input logic [7:0] b1,
                                   input logic [7:0] b2);
        exp_t e;
        e.xr  = {b0[4], b1};
        e.yr  = {b0[5], b2};
        e.x   = b0[6] ? (b0[4] ? 9'h101 : 9'h0FF) : e.xr;
        e.y   = b0[7] ? (b0[5] ? 9'h101 : 9'h0FF) : e.yr;
        e.btn = b0[2:0];
        e.ovf = b0[7:6];
        e.due = 0;
        return e;
    endfunction

    // One byte held for exactly one sampling edge; returns the negedge count at drive time.
    task automatic send(input logic [7:0] b, input logic err, output int drive_n);
        @(posedge clk);
        #1;
        byte_data  = b;
        byte_valid = 1'b1;
        byte_err   = err;
        drive_n    = ncnt;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        byte_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        int   dn;
        exp_t e;
        send(b0, 1'b0, dn);
        send(b1, 1'b0, dn);
        send(b2, 1'b0, dn);
        e     = model(b0, b1, b2);
        e.due = dn + 2;
        sbq.push_back(e);
        last_x = e.x;
        last_y = e.y;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        ncnt++;
        if (se_s) sync_seen++;
        if (pv_s || se_s) chk("pv_se_excl", {31'd0, pv_s & se_s}, 32'd0);
        if (pv_s) begin
            if (sbq.size() == 0) begin
                chk("pkt_unexpected", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("pkt_latency", ncnt, e.due);
                chk("x_axis", {23'd0, x_s}, {23'd0, e.x});
                chk("y_axis", {23'd0, y_s}, {23'd0, e.y});
                chk("buttons", {29'd0, bm_s, br_s, bl_s}, {29'd0, e.btn});
                chk("ovf", {30'd0, yo_s, xo_s}, {30'd0, e.ovf});
                chk("raw_pv", {31'd0, pv_r}, 32'd1);
                chk("raw_x", {23'd0, x_r}, {23'd0, e.xr});
                chk("raw_y", {23'd0, y_r}, {23'd0, e.yr});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dn;
        logic [7:0] r0, r1, r2;

        // Reset state
        idle(3);
        #1;
        chk("rst_x", {23'd0, x_s}, 32'd0);
        chk("rst_y", {23'd0, y_s}, 32'd0);
        chk("rst_flags", {25'd0, bl_s, br_s, bm_s, xo_s, yo_s, pv_s, se_s}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Basic packets and sign/overflow handling
        send_pkt(8'h18, 8'h10, 8'h05);
        send_pkt(8'h0F, 8'h7F, 8'h80);
        send_pkt(8'h58, 8'h00, 8'h00);
        send_pkt(8'h88, 8'h00, 8'h00);
        send_pkt(8'hB8, 8'h00, 8'h00);
        send_pkt(8'hF8, 8'hFF, 8'hFF);

        // Misaligned first byte
        send(8'h00, 1'b0, dn);
        sync_exp++;
        idle(3);
        chk("sync_misalign", sync_seen, sync_exp);
        send_pkt(8'h08, 8'h02, 8'h03);

        // Inter-byte timeout drops the partial packet
        send(8'h08, 1'b0, dn);
        send(8'h01, 1'b0, dn);
        idle(T + 5);
        sync_exp++;
        chk("sync_timeout", sync_seen, sync_exp);
        send_pkt(8'h08, 8'h02, 8'h03);

        // Third byte lands exactly on the expiry cycle: byte wins
        begin
            exp_t e;
            send(8'h08, 1'b0, dn);
            send(8'h01, 1'b0, dn);
            idle(T - 2);
            send(8'h05, 1'b0, dn);
            e     = model(8'h08, 8'h01, 8'h05);
            e.due = dn + 2;
            sbq.push_back(e);
            last_x = e.x;
            last_y = e.y;
        end
        idle(3);
        chk("sync_at_expiry", sync_seen, sync_exp);

        // One cycle later than expiry: timeout, then the late byte is misaligned
        send(8'h08, 1'b0, dn);
        send(8'h01, 1'b0, dn);
        idle(T - 1);
        send(8'h05, 1'b0, dn);
        sync_exp += 2;
        idle(3);
        chk("sync_past_expiry", sync_seen, sync_exp);

        // Receiver error on the X byte: partial dropped, outputs hold
        send(8'h08, 1'b0, dn);
        send(8'hAA, 1'b1, dn);
        sync_exp++;
        idle(3);
        chk("sync_byte_err", sync_seen, sync_exp);
        chk("hold_x", {23'd0, x_s}, {23'd0, last_x});
        chk("hold_y", {23'd0, y_s}, {23'd0, last_y});
        send_pkt(8'h08, 8'h02, 8'h03);

        // Random well-aligned packets
        for (int i = 0; i < 12; i++) begin
            r0 = 8'($urandom) | 8'h08;
            r1 = 8'($urandom);
            r2 = 8'($urandom);
            send_pkt(r0, r1, r2);
        end

        // Reset mid-packet clears outputs and realigns
        send(8'h08, 1'b0, dn);
        send(8'h01, 1'b0, dn);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("midrst_x", {23'd0, x_s}, 32'd0);
        chk("midrst_y", {23'd0, y_s}, 32'd0);
        chk("midrst_flags", {25'd0, bl_s, br_s, bm_s, xo_s, yo_s, pv_s, se_s}, 32'd0);
        chk("midrst_raw_x", {23'd0, x_r}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_pkt(8'h09, 8'h04, 8'h06);

        idle(5);
        chk("sb_empty", sbq.size(), 32'd0);
        chk("sync_total", sync_seen, sync_exp);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_packet_decoder.md
Name: ps2_packet_decoder

Overview:
- Assembles the 3-byte PS/2 mouse movement packet from the byte-level PS/2 receiver into registered 9-bit two's-complement X/Y deltas, button states and overflow flags.
- Sits between the PS/2 byte receiver and the arithmetic stage, which consumes x_axis/y_axis (bit 8 = sign).
- Handles packet alignment, receiver errors, inter-byte timeout and overflow saturation.

Parameters:
- TIMEOUT_CYCLES, 100000: max clk cycles between bytes inside a packet (2 ms at 50 MHz) before the partial packet is dropped.
- SAT_ON_OVF, 1: 1 = saturate the axis on its overflow bit; 0 = pass raw sign/data.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- byte_data  in  8  received byte, valid only with byte_valid
- byte_valid  in  1  single-cycle strobe; every high cycle is one byte
- byte_err  in  1  parity/frame error strobe from receiver (qualifies byte_valid)
- x_axis  out  9  X delta, two's complement {sign, data}
- y_axis  out  9  Y delta, two's complement, positive = up
- btn_left, btn_right, btn_middle  out  1 each  button states
- x_ovf, y_ovf  out  1 each  overflow bits of last packet
- pkt_valid  out  1  one-cycle pulse, outputs updated
- sync_err  out  1  one-cycle pulse: misaligned byte, byte error or timeout

Behaviour:
- Reset (async, rst_n=0): FSM=WAIT_B0, timeout counter=0, all outputs 0.
- FSM WAIT_B0 -> WAIT_B1 -> WAIT_B2 -> WAIT_B0. A byte is accepted only when byte_valid=1 and byte_err=0.
- WAIT_B0: accepted byte with bit3=1 -> latch status byte, go WAIT_B1. Bit3=0 -> sync_err pulse, stay.
- WAIT_B1: accepted byte -> latch X data, go WAIT_B2.
- WAIT_B2: accepted byte -> latch Y data, go WAIT_B0.
- Output update and pkt_valid occur on the cycle after byte 2 is accepted (one-cycle latency). Outputs hold until the next complete packet.
- Status byte mapping: bit0 = left, bit1 = right, bit2 = middle, bit4 = X sign, bit5 = Y sign, bit6 = X ovf, bit7 = Y ovf.
- Axis forming: x_axis = {status[4], X byte}; y_axis likewise with status[5] and the Y byte.
- SAT_ON_OVF=1 and ovf bit set:
  - positive sign -> 9'h0FF (+255).
  - negative sign -> 9'h101 (-255), never -256, so the downstream 8-bit magnitude cannot wrap to 0.
- x_ovf/y_ovf always reflect the raw status bits.
- byte_valid=1 with byte_err=1 in any state -> discard partial packet, sync_err pulse, go WAIT_B0. Outputs unchanged, no pkt_valid.
- Timeout:
  - Counter clears on every accepted byte and counts only in WAIT_B1/WAIT_B2.
  - At TIMEOUT_CYCLES-1 with no byte -> sync_err pulse, go WAIT_B0, counter=0.
  - Byte arriving on the same cycle as expiry: byte wins, no timeout.
- Reset mid-packet: partial data lost. The first post-reset byte is treated as byte 0.
- pkt_valid and sync_err are never high in the same cycle.

Test Plan:
- Bytes 0x18, 0x10, 0x05 -> one cycle after third byte: pkt_valid=1 for 1 cycle, x_axis=9'h110, y_axis=9'h005, buttons 0, ovf 0.
- Bytes 0x0F, 0x7F, 0x80 -> btn_left/right/middle=1, x_axis=9'h07F, y_axis=9'h080; sign bits follow status, not data bit7.
- Bytes 0x58, 0x00, 0x00 with SAT_ON_OVF=1 -> x_axis=9'h101, x_ovf=1, y_axis=9'h000. Same with SAT_ON_OVF=0 -> x_axis=9'h100. Bytes 0x88, 0x00, 0x00 -> y_axis=9'h0FF, y_ovf=1.
- Alignment: byte 0x00 -> sync_err pulse, no pkt_valid. Then 0x08, 0x02, 0x03 -> x_axis=9'h002, y_axis=9'h003.
- Timeout: 0x08, 0x01, then idle TIMEOUT_CYCLES -> sync_err pulse, no pkt_valid. Then 0x08, 0x02, 0x03 -> x=2, y=3. Also place byte 2 exactly at expiry -> packet completes, no sync_err.
- Errors/reset: byte_err with byte 1 -> sync_err, outputs keep previous packet. rst_n low after byte 1 -> all outputs 0, next three bytes 0x09, 0x04, 0x06 decode with btn_left=1, x=4, y=6.
